// File: rtl/glm_sbox_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : glm_sbox_sequencer
// Purpose  : Streams a two-share PRINCE state through one shared, pipelined
//            first-order GLM masked S-box, one nibble per cycle. The pipeline
//            only advances when fresh randomness is available. The shared
//            results are gathered back into a two-share output state.
// Revision : 1.0 - initial release
// ============================================================================
module glm_sbox_sequencer #(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state_in_s0,
    input  logic [4*NIBBLES-1:0] state_in_s1,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic                 sbox_en,
    output logic [3:0]           sbox_in_s0,
    output logic [3:0]           sbox_in_s1,
    input  logic [3:0]           sbox_out_s0,
    input  logic [3:0]           sbox_out_s1,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] state_out_s0,
    output logic [4*NIBBLES-1:0] state_out_s1
);

    localparam int c_W  = 4 * NIBBLES;
    localparam int c_CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NIBBLES - 1);

    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FEED    = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_CW-1:0]      r_issue_cnt;
    logic [c_CW-1:0]      r_retire_cnt;
    logic [SBOX_LAT-1:0]  r_vpipe;
    logic [SBOX_LAT-1:0]  w_vpipe_nxt;
    logic [c_W-1:0]       r_in_s0;
    logic [c_W-1:0]       r_in_s1;
    logic [c_W-1:0]       r_out_s0;
    logic [c_W-1:0]       r_out_s1;
    logic                 w_accept;
    logic                 w_en;
    logic                 w_retire;
    logic                 w_last_issue;
    logic                 w_last_retire;

    // Handshake and progress qualifiers shared by FSM and datapath
    always_comb begin
        w_accept      = (r_state == c_IDLE) && start;
        w_en          = ((r_state == c_FEED) || (r_state == c_DRAIN)) && rnd_valid;
        w_retire      = w_en && r_vpipe[SBOX_LAT-1];
        w_last_issue  = w_en && (r_state == c_FEED) && (r_issue_cnt == c_LAST);
        w_last_retire = w_retire && (r_retire_cnt == c_LAST);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_FEED;
            c_FEED:  if (w_last_issue) w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_last_retire) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs; idle S-box inputs are forced to zero so no recombined
    // value ever appears on the share wires outside FEED
    always_comb begin
        busy       = (r_state != c_IDLE);
        done       = (r_state == c_DONE);
        sbox_en    = w_en;
        rnd_ready  = w_en;
        sbox_in_s0 = 4'd0;
        sbox_in_s1 = 4'd0;
        if (r_state == c_FEED) begin
            sbox_in_s0 = r_in_s0[{r_issue_cnt, 2'b00} +: 4];
            sbox_in_s1 = r_in_s1[{r_issue_cnt, 2'b00} +: 4];
        end
    end

    // Valid pipe shift value: tags issued nibbles as they travel the S-box
    always_comb begin
        w_vpipe_nxt    = r_vpipe;
        w_vpipe_nxt[0] = (r_state == c_FEED);
        for (int i = 1; i < SBOX_LAT; i++) begin
            w_vpipe_nxt[i] = r_vpipe[i-1];
        end
    end

    // Capture of input shares, issue/retire counters and the valid pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_s0      <= '0;
            r_in_s1      <= '0;
            r_issue_cnt  <= '0;
            r_retire_cnt <= '0;
            r_vpipe      <= '0;
        end else if (w_accept) begin
            r_in_s0      <= state_in_s0;
            r_in_s1      <= state_in_s1;
            r_issue_cnt  <= '0;
            r_retire_cnt <= '0;
            r_vpipe      <= '0;
        end else if (w_en) begin
            r_vpipe <= w_vpipe_nxt;
            if ((r_state == c_FEED) && (r_issue_cnt != c_LAST)) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_retire && (r_retire_cnt != c_LAST)) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
        end
    end

    // Result collection: each share written separately into its own nibble slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_s0 <= '0;
            r_out_s1 <= '0;
        end else if (w_retire) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (r_retire_cnt == c_CW'(i)) begin
                    r_out_s0[4*i +: 4] <= sbox_out_s0;
                    r_out_s1[4*i +: 4] <= sbox_out_s1;
                end
            end
        end
    end

    assign state_out_s0 = r_out_s0;
    assign state_out_s1 = r_out_s1;

endmodule
`default_nettype wire

// File: tb/tb_glm_sbox_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_glm_sbox_sequencer
// Purpose  : Scoreboard bench for glm_sbox_sequencer with a behavioural
//            pipelined S-box (identity or masked PRINCE S-box).
// Revision : 1.0 - initial release
// ============================================================================
module tb_glm_sbox_sequencer;

    localparam int NIBBLES  = 16;
    parameter  int SBOX_LAT = 2;
    localparam int c_LAT_DONE = NIBBLES + SBOX_LAT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] state_in_s0 = '0;
    logic [63:0] state_in_s1 = '0;
    logic        rnd_valid = 1'b0;
    logic        rnd_ready;
    logic        sbox_en;
    logic [3:0]  sbox_in_s0;
    logic [3:0]  sbox_in_s1;
    logic [3:0]  sbox_out_s0;
    logic [3:0]  sbox_out_s1;
    logic        busy;
    logic        done;
    logic [63:0] state_out_s0;
    logic [63:0] state_out_s1;

    glm_sbox_sequencer #(
        .NIBBLES (NIBBLES),
        .SBOX_LAT(SBOX_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_in_s0 (state_in_s0),
        .state_in_s1 (state_in_s1),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .sbox_en     (sbox_en),
        .sbox_in_s0  (sbox_in_s0),
        .sbox_in_s1  (sbox_in_s1),
        .sbox_out_s0 (sbox_out_s0),
        .sbox_out_s1 (sbox_out_s1),
        .busy        (busy),
        .done        (done),
        .state_out_s0(state_out_s0),
        .state_out_s1(state_out_s1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- S-box model: SBOX_LAT register stages -----------------
    int mode = 0;  // 0: identity, 1: masked PRINCE S-box

    function automatic logic [3:0] prince_s(input logic [3:0] x);
        case (x)
            4'h0: prince_s = 4'hB; 4'h1: prince_s = 4'hF;
            4'h2: prince_s = 4'h3; 4'h3: prince_s = 4'h2;
            4'h4: prince_s = 4'hA; 4'h5: prince_s = 4'hC;
            4'h6: prince_s = 4'h9; 4'h7: prince_s = 4'h1;
            4'h8: prince_s = 4'h6; 4'h9: prince_s = 4'h7;
            4'hA: prince_s = 4'h8; 4'hB: prince_s = 4'h0;
            4'hC: prince_s = 4'hE; 4'hD: prince_s = 4'h5;
            4'hE: prince_s = 4'hD; default: prince_s = 4'h4;
        endcase
    endfunction

    logic [3:0] m0 [SBOX_LAT];
    logic [3:0] m1 [SBOX_LAT];
    logic [3:0] f1;
    logic [3:0] f0;

    always_comb begin
        f1 = (mode == 1) ? (sbox_in_s1 ^ 4'h5) : sbox_in_s1;
        f0 = (mode == 1) ? (prince_s(sbox_in_s0 ^ sbox_in_s1) ^ f1) : sbox_in_s0;
    end

    always @(posedge clk) begin
        if (sbox_en) begin
            m0[0] <= f0;
            m1[0] <= f1;
            for (int i = 1; i < SBOX_LAT; i++) begin
                m0[i] <= m0[i-1];
                m1[i] <= m1[i-1];
            end
        end
    end

    assign sbox_out_s0 = m0[SBOX_LAT-1];
    assign sbox_out_s1 = m1[SBOX_LAT-1];

    // ---------------- Scoreboard and monitor --------------------------------
    typedef struct {
        logic [63:0] s0;
        logic [63:0] s1;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic push(input logic [63:0] s0, input logic [63:0] s1, input int dcyc);
        exp_t e;
        e.s0  = s0;
        e.s1  = s1;
        e.cyc = dcyc;
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("state_out_s0", state_out_s0, e.s0);
                    chk("state_out_s1", state_out_s1, e.s1);
                end
            end
        end
    end

    // ---------------- Stimulus ----------------------------------------------
    // Drives n cycles starting right after a rising edge. Bit r of st_m / stl_m
    // gives start / stalled randomness in relative cycle r. Input shares are
    // garbage after cycle 0 so any late capture corrupts the result.
    task automatic drive(input logic [63:0] s0, input logic [63:0] s1, input int n,
                         input logic [127:0] st_m, input logic [127:0] stl_m,
                         input bit chk_en);
        logic [3:0]  h0;
        logic [3:0]  h1;
        logic [63:0] t0;
        logic [63:0] t1;
        h0 = '0;
        h1 = '0;
        for (int r = 0; r < n; r++) begin
            start       = st_m[r];
            rnd_valid   = !stl_m[r];
            state_in_s0 = (r == 0) ? s0 : ~s0;
            state_in_s1 = (r == 0) ? s1 : ~s1;
            @(negedge clk);
            if (r > 0 && stl_m[r-1]) begin
                chk("stall_hold_s0", 64'(sbox_in_s0), 64'(h0));
                chk("stall_hold_s1", 64'(sbox_in_s1), 64'(h1));
            end
            if (chk_en) begin
                chk("sbox_en", 64'(sbox_en), 64'(r >= 1 && r <= NIBBLES + SBOX_LAT));
                chk("rnd_ready", 64'(rnd_ready), 64'(r >= 1 && r <= NIBBLES + SBOX_LAT));
                t0 = (r >= 1 && r <= NIBBLES) ? (s0 >> (4 * (r - 1))) : 64'd0;
                t1 = (r >= 1 && r <= NIBBLES) ? (s1 >> (4 * (r - 1))) : 64'd0;
                chk("sbox_in_s0", 64'(sbox_in_s0), 64'(t0[3:0]));
                chk("sbox_in_s1", 64'(sbox_in_s1), 64'(t1[3:0]));
            end
            h0 = sbox_in_s0;
            h1 = sbox_in_s1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sbox_en", 64'(sbox_en), 64'd0);
        chk("rst_sbox_in", 64'({sbox_in_s0, sbox_in_s1}), 64'd0);
        chk("rst_out_s0", state_out_s0, 64'd0);
        chk("rst_out_s1", state_out_s1, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rnd_valid = 1'b1;
        @(posedge clk);
        #1;

        // Nominal: identity S-box, no stalls
        mode = 0;
        push(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, cyc + c_LAT_DONE);
        drive(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, c_LAT_DONE + 1, 128'h1, 128'h0, 1'b1);

        // Stalls in cycles 5, 6 and 17
        push(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, cyc + c_LAT_DONE + 3);
        drive(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, c_LAT_DONE + 4, 128'h1,
              (128'h1 << 5) | (128'h1 << 6) | (128'h1 << 17), 1'b0);

        // Starts while busy and in the done cycle are ignored
        push(64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978, cyc + c_LAT_DONE);
        drive(64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978, c_LAT_DONE + 1,
              128'h1 | (128'h1 << 3) | (128'h1 << c_LAT_DONE), 128'h0, 1'b0);
        // Start in the cycle after done begins a new layer
        push(64'h1122334455667788, 64'h8877665544332211, cyc + c_LAT_DONE);
        drive(64'h1122334455667788, 64'h8877665544332211, c_LAT_DONE + 1, 128'h1, 128'h0, 1'b0);

        // Masked PRINCE S-box: shares of zero recombine to S(0)=B in every nibble
        mode = 1;
        push(64'hEFCDAB8967452301, 64'h54761032DCFE98BA, cyc + c_LAT_DONE);
        drive(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, c_LAT_DONE + 1, 128'h1, 128'h0, 1'b0);
        // Secret 0xFEDCBA9876543210 with an all-zero share 1
        push(64'h180B5D234C9F76AE, 64'h5555555555555555, cyc + c_LAT_DONE);
        drive(64'hFEDCBA9876543210, 64'h0000000000000000, c_LAT_DONE + 1, 128'h1, 128'h0, 1'b0);

        // Reset in cycle 10 of a layer aborts it without a done pulse
        mode = 0;
        drive(64'hA5A5A5A5A5A5A5A5, 64'h3C3C3C3C3C3C3C3C, 10, 128'h1, 128'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sbox_en", 64'(sbox_en), 64'd0);
        chk("abort_out_s0", state_out_s0, 64'd0);
        chk("abort_out_s1", state_out_s1, 64'd0);
        @(posedge clk);
        #1;
        drive(64'h0, 64'h0, 12, 128'h0, 128'h0, 1'b0);
        push(64'h0F0F0F0F12345678, 64'h9ABCDEF000000000, cyc + c_LAT_DONE);
        drive(64'h0F0F0F0F12345678, 64'h9ABCDEF000000000, c_LAT_DONE + 3, 128'h1, 128'h0, 1'b0);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
